// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (used by load_store_unit).
package lsu_pkg;

    // Byte lane within a 32-bit word, and word index within a 32-bit byte address.
    localparam int unsigned LaneW    = 2;
    localparam int unsigned WordIdxW = 32 - LaneW;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } lsu_state_e;

    typedef enum logic {
        SizeWord,
        SizeByte
    } lsu_size_e;

    // Byte write enables for a store of the given size at the given lane.
    function automatic logic [3:0] byte_enable(input lsu_size_e size, input logic [LaneW-1:0] lane);
        logic [3:0] be;
        be = 4'hF;
        if (size == SizeByte) begin
            be = 4'b0001 << lane;
        end
        return be;
    endfunction

    // Load result: full word, or the addressed lane zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [LaneW-1:0] lane,
                                                 input lsu_size_e size);
        logic [31:0] res;
        res = word;
        if (size == SizeByte) begin
            res = {24'h0, word[{lane, 3'b000} +: 8]};
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enable, 1-cycle read latency.
// Contents are not initialised or reset.
module sram_1rw #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [AddrW-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [Depth];
    logic [31:0] r_rdata;

    // Byte-masked write, or registered read; read data holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding sw/sb/lw/lbu request against a local data memory.
// Stores respond 1 cycle after acceptance, loads 2 cycles after.
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, word accesses with
// addr[1:0] != 0 are rejected with resp_err; otherwise they are aligned down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    lsu_state_e          r_state;
    lsu_state_e          w_state_next;
    lsu_size_e           r_size;
    logic [LaneW-1:0]    r_lane;
    logic                r_err;
    logic                r_zero;   // response data forced to 0 (store, out of range, misaligned)
    logic [31:0]         r_rdata;

    lsu_size_e           w_size;
    logic [WordIdxW-1:0] w_word_idx;
    logic [LaneW-1:0]    w_lane;
    logic                w_in_range;
    logic                w_misalign;
    logic                w_accept;
    logic                w_mem_en;
    logic [3:0]          w_mem_be;
    logic [31:0]         w_mem_wdata;
    logic [31:0]         w_mem_rdata;

    assign w_size     = req_byte ? SizeByte : SizeWord;
    assign w_word_idx = req_addr[31:LaneW];
    assign w_lane     = req_addr[LaneW-1:0];
    assign w_in_range = ({{LaneW{1'b0}}, w_word_idx} < DEPTH);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = (w_size == SizeWord) && (w_lane != '0);
`else
    assign w_misalign = 1'b0;
`endif

    assign req_ready   = (r_state == StIdle);
    assign w_accept    = req_valid && req_ready && !reset;
    // Out-of-range and misaligned requests never touch the RAM.
    assign w_mem_en    = w_accept && w_in_range && !w_misalign;
    assign w_mem_be    = byte_enable(w_size, w_lane);
    assign w_mem_wdata = (w_size == SizeByte) ? {4{req_wdata[7:0]}} : req_wdata;

    sram_1rw #(
        .Depth (DEPTH),
        .AddrW (AddrW)
    ) u_sram (
        .i_clk   (clk),
        .i_en    (w_mem_en),
        .i_we    (req_we),
        .i_be    (w_mem_be),
        .i_addr  (w_word_idx[AddrW-1:0]),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: stores skip READ, RESP always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = req_we ? StResp : StRead;
                end
            end
            StRead:  w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Latch request attributes at acceptance; format load data while in READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size  <= SizeWord;
            r_lane  <= '0;
            r_err   <= 1'b0;
            r_zero  <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_size  <= w_size;
            r_lane  <= w_lane;
            r_err   <= w_misalign;
            r_zero  <= req_we || !w_in_range || w_misalign;
            r_rdata <= '0;
        end else if (r_state == StRead) begin
            r_rdata <= r_zero ? 32'h0 : lane_extract(w_mem_rdata, r_lane, r_size);
        end
    end

    assign resp_valid = (r_state == StResp);
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_err   = resp_valid && r_err;

endmodule
